// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// MEM stage of a 5-stage MIPS pipeline together with the MEM/WB pipeline
// register. Drives the data-memory bus for loads and stores (byte-enable lane
// alignment, store-data replication, load-data extraction and extension),
// stalls the front of the pipeline while a slow memory is busy, and reports
// misaligned accesses and bus timeouts to the hazard unit.
//
// Parameters
//   TIMEOUT      max cycles to wait for dmem_ready before a bus error (1..255)
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   RegWriteM .. WriteRegM   EX/MEM register contents (control + data)
//   dmem_req/we/addr/be/wdata data-memory request side
//   dmem_rdata/ready         data-memory response side
//   StallM                   freeze IF/ID/EX and EX/MEM while memory is busy
//   ExcM                     one-cycle pulse: 01 misaligned, 10 bus timeout
//   RegWriteW .. WriteRegW   MEM/WB register outputs
//   dbg_state_o              current FSM state (0 = IDLE, 1 = WAIT)
//
// Bus handshake: dmem_req is held high, with addr/be/we/wdata stable, from
// the first cycle of an access until the cycle dmem_ready is seen high; that
// cycle completes the access (read data is sampled in the same cycle).
// dmem_ready while dmem_req is low carries no meaning and is ignored.
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX/MEM inputs
    input  logic        RegWriteM,
    input  logic        MemToRegM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    // data-memory bus
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    // hazard unit
    output logic        StallM,
    output logic [1:0]  ExcM,
    // MEM/WB outputs
    output logic        RegWriteW,
    output logic        MemToRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    // debug
    output logic        dbg_state_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        rw_q, rw_d;
    logic        mtr_q, mtr_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  wr_q, wr_d;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic        mem_op;
    logic        aligned;
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw;

    always_comb begin
        mem_op    = MemReadM | MemWriteM;
        aligned   = 1'b1;
        be_raw    = 4'b0000;
        wdata_raw = WriteDataM;
        case (MemSizeM)
            2'b00: begin
                aligned   = 1'b1;
                be_raw    = 4'b0001 << ALUOutM[1:0];
                wdata_raw = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                aligned   = ~ALUOutM[0];
                be_raw    = ALUOutM[1] ? 4'b1100 : 4'b0011;
                wdata_raw = {2{WriteDataM[15:0]}};
            end
            default: begin
                // 10 = word; reserved 11 behaves the same
                aligned   = (ALUOutM[1:0] == 2'b00);
                be_raw    = 4'b1111;
                wdata_raw = WriteDataM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data: pick the lane addressed by the low address bits, then
    // zero- or sign-extend. Words pass unchanged.
    // ------------------------------------------------------------------
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;

    always_comb begin
        lane_b = 8'h00;
        case (ALUOutM[1:0])
            2'b00:   lane_b = dmem_rdata[7:0];
            2'b01:   lane_b = dmem_rdata[15:8];
            2'b10:   lane_b = dmem_rdata[23:16];
            default: lane_b = dmem_rdata[31:24];
        endcase
        lane_h = ALUOutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (MemSizeM)
            2'b00:   load_ext = {{24{MemSignedM & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{MemSignedM & lane_h[15]}}, lane_h};
            default: load_ext = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Stall FSM
    // ------------------------------------------------------------------
    logic       req;
    logic       stall;
    logic [1:0] exc;
    logic       done;    // access completes this cycle
    logic       bubble;  // instruction retires without writing a register

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        stall   = 1'b0;
        exc     = 2'b00;
        done    = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (!aligned) begin
                        exc    = 2'b01;
                        bubble = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (dmem_ready) begin
                            done = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            state_d = S_WAIT;
                            cnt_d   = 8'd1;
                        end
                    end
                end
            end
            S_WAIT: begin
                // EX/MEM is frozen, so the bus fields computed from the M
                // inputs are the same ones presented in the IDLE cycle.
                req = 1'b1;
                if (dmem_ready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q >= TIMEOUT_C) begin
                    exc     = 2'b10;
                    bubble  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register. A stall injects a bubble (no register write) while
    // the data fields hold; ReadDataW only changes on a completed load.
    // ------------------------------------------------------------------
    always_comb begin
        rw_d  = rw_q;
        mtr_d = mtr_q;
        rd_d  = rd_q;
        alu_d = alu_q;
        wr_d  = wr_q;
        if (stall) begin
            rw_d = 1'b0;
        end else begin
            rw_d  = RegWriteM & ~bubble;
            mtr_d = MemToRegM;
            alu_d = ALUOutM;
            wr_d  = WriteRegM;
            if (done && MemReadM) begin
                rd_d = load_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q  <= 1'b0;
            mtr_q <= 1'b0;
            rd_q  <= 32'd0;
            alu_q <= 32'd0;
            wr_q  <= 5'd0;
        end else begin
            rw_q  <= rw_d;
            mtr_q <= mtr_d;
            rd_q  <= rd_d;
            alu_q <= alu_d;
            wr_q  <= wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Combinational strobes are gated by rst_n so that asserting
    // reset mid-access drops the request immediately, even though the
    // frozen EX/MEM inputs still describe a memory operation.
    // ------------------------------------------------------------------
    assign dmem_req    = rst_n & req;
    assign dmem_we     = rst_n & req & MemWriteM;
    assign dmem_be     = (rst_n & req) ? be_raw : 4'b0000;
    assign dmem_addr   = {ALUOutM[31:2], 2'b00};
    assign dmem_wdata  = wdata_raw;
    assign StallM      = rst_n & stall;
    assign ExcM        = rst_n ? exc : 2'b00;

    assign RegWriteW   = rw_q;
    assign MemToRegW   = mtr_q;
    assign ReadDataW   = rd_q;
    assign ALUOutW     = alu_q;
    assign WriteRegW   = wr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage (TIMEOUT = 4). Inputs change on the
// falling clock edge; combinational bus outputs are checked 1 ns later and
// MEM/WB outputs 1 ns after the rising edge. Expected MEM/WB contents are
// pushed to exp_q when an instruction is driven and popped when it retires.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    localparam int TO = 4;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic        RegWriteM, MemToRegM, MemReadM, MemWriteM, MemSignedM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        StallM;
    logic [1:0]  ExcM;
    logic        RegWriteW, MemToRegW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;
    logic        dbg_state_o;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemReadM(MemReadM),
        .MemWriteM(MemWriteM), .MemSizeM(MemSizeM), .MemSignedM(MemSignedM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .StallM(StallM), .ExcM(ExcM),
        .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .ReadDataW(ReadDataW),
        .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .dbg_state_o(dbg_state_o)
    );

    // scoreboard: {RegWriteW, MemToRegW, ReadDataW, ALUOutW, WriteRegW}
    logic [70:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_rd = 32'd0;   // model of the held ReadDataW

    function automatic logic [70:0] w_pack();
        return {RegWriteW, MemToRegW, ReadDataW, ALUOutW, WriteRegW};
    endfunction

    // ---------------- reference models ----------------
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sgn);
        logic [31:0] sh;
        sh = rd >> {a[1:0], 3'b000};
        case (sz)
            2'b00:   return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
            2'b01:   return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001 << a[1:0];
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
        case (sz)
            2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            2'b01:   return {wd[15:0], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rw, input logic mtr, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic sgn, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] wreg);
        RegWriteM  = rw;
        MemToRegM  = mtr;
        MemReadM   = rd;
        MemWriteM  = wr;
        MemSizeM   = sz;
        MemSignedM = sgn;
        ALUOutM    = a;
        WriteDataM = wd;
        WriteRegM  = wreg;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 5'd0);
        dmem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 5'd4);
        dmem_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({dmem_req, dmem_we, StallM, ExcM} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_strobes: got %b expected 00000", {dmem_req, dmem_we, StallM, ExcM});
        end
        n_cmp++;
        if (w_pack() !== 71'd0) begin
            n_err++;
            $display("FAIL reset_wb: got %h expected 0", w_pack());
        end
        n_cmp++;
        if (dbg_state_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got %b expected 0", dbg_state_o);
        end
        @(negedge clk);
        nop();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads();
        logic [31:0] a, rd, ld;
        logic [1:0]  sz;
        logic        sgn;
        logic [4:0]  wr;
        logic [40:0] bus_exp;
        logic [70:0] e;
        for (int i = 0; i < 12; i++) begin
            wr = 5'($urandom_range(1, 31));
            case (i)
                0: begin a = 32'h100; sz = 2'b10; sgn = 1'b0; rd = 32'hDEADBEEF; end
                1: begin a = 32'h103; sz = 2'b00; sgn = 1'b1; rd = 32'h80112233; end
                2: begin a = 32'h103; sz = 2'b00; sgn = 1'b0; rd = 32'h80112233; end
                3: begin a = 32'h202; sz = 2'b01; sgn = 1'b1; rd = 32'h80017FFF; end
                4: begin a = 32'h200; sz = 2'b01; sgn = 1'b1; rd = 32'h80017FFF; end
                5: begin a = 32'h010; sz = 2'b11; sgn = 1'b1; rd = 32'h89ABCDEF; end
                default: begin
                    a   = $urandom;
                    sz  = 2'($urandom_range(0, 2));
                    sgn = 1'($urandom_range(0, 1));
                    rd  = $urandom;
                    if (sz == 2'b10) a[1:0] = 2'b00;
                    else if (sz == 2'b01) a[0] = 1'b0;
                end
            endcase
            drive(1'b1, 1'b1, 1'b1, 1'b0, sz, sgn, a, 32'h0, wr);
            dmem_rdata = rd;
            dmem_ready = 1'b1;
            ld = model_load(rd, a, sz, sgn);
            if (i == 0 && ld !== 32'hDEADBEEF) $display("note: model word load differs");
            exp_q.push_back({1'b1, 1'b1, ld, a, wr});
            last_rd = ld;
            #1;
            bus_exp = {1'b1, 1'b0, model_be(a, sz), a[31:2], 2'b00, 1'b0, 2'b00};
            n_cmp++;
            if ({dmem_req, dmem_we, dmem_be, dmem_addr, StallM, ExcM} !== bus_exp) begin
                n_err++;
                $display("FAIL load_bus[%0d]: got %h expected %h", i,
                         {dmem_req, dmem_we, dmem_be, dmem_addr, StallM, ExcM}, bus_exp);
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (w_pack() !== e) begin
                n_err++;
                $display("FAIL load_wb[%0d]: got %h expected %h", i, w_pack(), e);
            end
            @(negedge clk);
        end
        nop();
    endtask

    task automatic test_stores();
        logic [31:0] a, wd;
        logic [1:0]  sz;
        logic [4:0]  wr;
        logic [38:0] bus_exp;
        logic [70:0] e;
        for (int i = 0; i < 6; i++) begin
            wr = 5'($urandom_range(0, 31));
            case (i)
                0: begin a = 32'h102; sz = 2'b01; wd = 32'h0000ABCD; end
                1: begin a = 32'h101; sz = 2'b00; wd = 32'hFFFFFF5A; end
                2: begin a = 32'h204; sz = 2'b10; wd = 32'h12345678; end
                default: begin
                    a  = $urandom;
                    wd = $urandom;
                    sz = 2'($urandom_range(0, 2));
                    if (sz == 2'b10) a[1:0] = 2'b00;
                    else if (sz == 2'b01) a[0] = 1'b0;
                end
            endcase
            drive(1'b0, 1'b0, 1'b0, 1'b1, sz, 1'b0, a, wd, wr);
            dmem_rdata = $urandom;
            dmem_ready = 1'b1;
            exp_q.push_back({1'b0, 1'b0, last_rd, a, wr});
            #1;
            bus_exp = {1'b1, 1'b1, model_be(a, sz), model_wdata(wd, sz), StallM};
            bus_exp[0] = 1'b0;
            n_cmp++;
            if ({dmem_req, dmem_we, dmem_be, dmem_wdata, StallM} !== bus_exp) begin
                n_err++;
                $display("FAIL store_bus[%0d]: got %h expected %h", i,
                         {dmem_req, dmem_we, dmem_be, dmem_wdata, StallM}, bus_exp);
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (w_pack() !== e) begin
                n_err++;
                $display("FAIL store_wb[%0d]: got %h expected %h", i, w_pack(), e);
            end
            @(negedge clk);
        end
        nop();
    endtask

    task automatic test_wait_load();
        logic [31:0] a, rd, ld;
        logic [1:0]  sz;
        logic [70:0] e;
        int          stalls;
        for (int k = 0; k < 2; k++) begin
            int d;
            d  = (k == 0) ? 3 : 1;
            a  = (k == 0) ? 32'h300 : 32'h305;
            sz = (k == 0) ? 2'b10 : 2'b00;
            rd = 32'hA5C3_E17F;
            ld = model_load(rd, a, sz, 1'b0);
            stalls = 0;
            drive(1'b1, 1'b1, 1'b1, 1'b0, sz, 1'b0, a, 32'h0, 5'd7);
            dmem_rdata = 32'h0;
            dmem_ready = 1'b0;
            for (int c = 0; c < d; c++) begin
                #1;
                if (StallM === 1'b1) stalls++;
                n_cmp++;
                if ({dmem_req, dmem_addr} !== {1'b1, a[31:2], 2'b00}) begin
                    n_err++;
                    $display("FAIL wait_bus[%0d.%0d]: got %h expected %h", k, c,
                             {dmem_req, dmem_addr}, {1'b1, a[31:2], 2'b00});
                end
                @(posedge clk);
                #1;
                n_cmp++;
                if (RegWriteW !== 1'b0) begin
                    n_err++;
                    $display("FAIL wait_bubble[%0d.%0d]: got %b expected 0", k, c, RegWriteW);
                end
                @(negedge clk);
            end
            dmem_rdata = rd;
            dmem_ready = 1'b1;
            exp_q.push_back({1'b1, 1'b1, ld, a, 5'd7});
            last_rd = ld;
            #1;
            n_cmp++;
            if (StallM !== 1'b0 || stalls != d) begin
                n_err++;
                $display("FAIL wait_stalls[%0d]: got stall=%b count=%0d expected stall=0 count=%0d",
                         k, StallM, stalls, d);
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (w_pack() !== e) begin
                n_err++;
                $display("FAIL wait_wb[%0d]: got %h expected %h", k, w_pack(), e);
            end
            // following ALU instruction retires on the very next cycle
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0, 5'd9);
            dmem_ready = 1'b0;
            exp_q.push_back({1'b1, 1'b0, last_rd, 32'h55, 5'd9});
            #1;
            n_cmp++;
            if ({dmem_req, StallM} !== 2'b00) begin
                n_err++;
                $display("FAIL alu_after_wait[%0d]: got %b expected 00", k, {dmem_req, StallM});
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (w_pack() !== e) begin
                n_err++;
                $display("FAIL alu_wb[%0d]: got %h expected %h", k, w_pack(), e);
            end
            @(negedge clk);
        end
        nop();
    endtask

    task automatic test_misaligned();
        logic [31:0] a;
        logic [1:0]  sz;
        logic        rd;
        logic [70:0] e;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin a = 32'h101; sz = 2'b10; rd = 1'b1; end
                1:       begin a = 32'h103; sz = 2'b01; rd = 1'b1; end
                default: begin a = 32'h102; sz = 2'b10; rd = 1'b0; end
            endcase
            drive(1'b1, rd, rd, ~rd, sz, 1'b1, a, 32'hCAFEF00D, 5'd12);
            dmem_rdata = 32'h1234_5678;
            dmem_ready = 1'b1;   // no request is out, so this must be ignored
            exp_q.push_back({1'b0, rd, last_rd, a, 5'd12});
            #1;
            n_cmp++;
            if ({dmem_req, dmem_we, StallM, ExcM} !== 5'b00001) begin
                n_err++;
                $display("FAIL misalign_exc[%0d]: got %b expected 00001", i,
                         {dmem_req, dmem_we, StallM, ExcM});
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (w_pack() !== e) begin
                n_err++;
                $display("FAIL misalign_wb[%0d]: got %h expected %h", i, w_pack(), e);
            end
            @(negedge clk);
            nop();
            #1;
            n_cmp++;
            if (ExcM !== 2'b00) begin
                n_err++;
                $display("FAIL misalign_pulse[%0d]: got %b expected 00", i, ExcM);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        logic [70:0] e;
        int          stalls;
        bit          expired;
        stalls  = 0;
        expired = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd3);
        dmem_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (StallM !== 1'b1) begin
                expired = 1'b0;
                break;
            end
            stalls++;
            @(posedge clk);
            #1;
            n_cmp++;
            if (RegWriteW !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_bubble[%0d]: got %b expected 0", c, RegWriteW);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (expired) begin
            n_err++;
            $display("FAIL timeout_bound: StallM still high after 20 cycles, expected release after %0d", TO);
        end else if (stalls != TO || ExcM !== 2'b10) begin
            n_err++;
            $display("FAIL timeout_exc: got stalls=%0d ExcM=%b expected stalls=%0d ExcM=10",
                     stalls, ExcM, TO);
        end
        exp_q.push_back({1'b0, 1'b1, last_rd, 32'h400, 5'd3});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (w_pack() !== e) begin
            n_err++;
            $display("FAIL timeout_wb: got %h expected %h", w_pack(), e);
        end
        @(negedge clk);
        nop();
        #1;
        n_cmp++;
        if ({ExcM, dmem_req, StallM, dbg_state_o} !== 5'b0) begin
            n_err++;
            $display("FAIL timeout_idle: got %b expected 00000", {ExcM, dmem_req, StallM, dbg_state_o});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        logic [70:0] e;
        // retry of the timed-out load, aborted by reset while in WAIT
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd3);
        dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({StallM, dbg_state_o} !== 2'b11) begin
            n_err++;
            $display("FAIL retry_wait: got %b expected 11", {StallM, dbg_state_o});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dmem_req, StallM, ExcM, dbg_state_o} !== 5'b0 || w_pack() !== 71'd0) begin
            n_err++;
            $display("FAIL reset_mid_wait: got strobes %b wb %h expected 0 / 0",
                     {dmem_req, StallM, ExcM, dbg_state_o}, w_pack());
        end
        last_rd = 32'd0;
        @(negedge clk);
        nop();
        rst_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h77, 32'h0, 5'd5);
        exp_q.push_back({1'b1, 1'b0, last_rd, 32'h77, 5'd5});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (w_pack() !== e) begin
            n_err++;
            $display("FAIL after_reset_wb: got %h expected %h", w_pack(), e);
        end
        @(negedge clk);
        nop();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, rd, ld;
        logic [1:0]  sz;
        logic        sgn, is_load;
        logic [4:0]  wr;
        logic [70:0] e;
        for (int i = 0; i < 10; i++) begin
            is_load = 1'($urandom_range(0, 1));
            a   = $urandom;
            rd  = $urandom;
            wr  = 5'($urandom_range(0, 31));
            sz  = 2'($urandom_range(0, 2));
            sgn = 1'($urandom_range(0, 1));
            if (sz == 2'b10) a[1:0] = 2'b00;
            else if (sz == 2'b01) a[0] = 1'b0;
            dmem_rdata = rd;
            // ALU ops get a random stray ready, which must not disturb anything
            dmem_ready = is_load ? 1'b1 : 1'($urandom_range(0, 1));
            if (is_load) begin
                drive(1'b1, 1'b1, 1'b1, 1'b0, sz, sgn, a, 32'h0, wr);
                ld = model_load(rd, a, sz, sgn);
                last_rd = ld;
                exp_q.push_back({1'b1, 1'b1, ld, a, wr});
            end else begin
                drive(1'b1, 1'b0, 1'b0, 1'b0, sz, sgn, a, 32'h0, wr);
                exp_q.push_back({1'b1, 1'b0, last_rd, a, wr});
            end
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (w_pack() !== e) begin
                n_err++;
                $display("FAIL b2b_wb[%0d]: got %h expected %h", i, w_pack(), e);
            end
            @(negedge clk);
        end
        nop();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        nop();
        dmem_rdata = 32'd0;
        test_reset();
        test_loads();
        test_stores();
        test_wait_load();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline plus the MEM/WB pipeline register.
- Takes EX/MEM results, drives the data-memory bus with byte-enable alignment, waits out slow memory with a stall FSM, then latches results for the writeback stage.
- Flags misaligned accesses and bus timeouts to the hazard unit.

Parameters:
- TIMEOUT, 16, max wait cycles for dmem_ready before bus error (range 1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- RegWriteM  in  1  instruction writes a register
- MemToRegM  in  1  result comes from memory
- MemReadM  in  1  load
- MemWriteM  in  1  store
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- MemSignedM  in  1  sign-extend load data
- ALUOutM  in  32  effective address / ALU result
- WriteDataM  in  32  store data, right-justified
- WriteRegM  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word address: {ALUOutM[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data, valid with dmem_ready
- dmem_ready  in  1  access complete this cycle
- StallM  out  1  freeze IF/ID/EX and EX/MEM registers
- ExcM  out  2  pulse: 01 misaligned, 10 bus timeout, 00 none
- RegWriteW  out  1  registered
- MemToRegW  out  1  registered
- ReadDataW  out  32  registered, aligned and extended load data
- ALUOutW  out  32  registered
- WriteRegW  out  5  registered

Behaviour:
- Reset (async, rst_n=0): state IDLE, timeout counter 0; all W outputs 0; StallM, ExcM, dmem_req 0.
- mem_op = MemReadM|MemWriteM. Alignment: word needs addr[1:0]=00, half needs addr[0]=0.
- Misaligned mem_op: no dmem_req; ExcM=01 for one cycle; W stage gets a bubble (RegWriteW=0); no stall.
- Byte enables: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) / 1100 (addr[1]=1); word 1111. Little-endian lanes.
- Store data: byte replicated x4, half replicated x2, word as-is.
- Load data: select lane by addr[1:0]; zero- or sign-extend to 32 per MemSignedM; word passes unchanged.
- FSM states IDLE, WAIT.
  - IDLE, aligned mem_op: dmem_req=1 combinationally. If dmem_ready same cycle: zero-wait completion, stay IDLE, StallM=0. Else StallM=1, go WAIT, counter=1.
  - WAIT: dmem_req=1, bus outputs held (EX/MEM is stalled so inputs are stable); StallM=1 until completion. On dmem_ready: StallM=0 that cycle, capture, go IDLE. If counter reaches TIMEOUT without ready: ExcM=10 pulse, bubble into W, StallM=0, go IDLE, counter cleared. Otherwise counter++.
  - Non-mem instruction: no request, no stall; passes straight through in one cycle.
- MEM/WB register: updates every cycle when StallM=0. While StallM=1 it loads a bubble: RegWriteW=0, other W fields hold their values. Latency: 1 cycle from EX/MEM to W with no wait states, 1+N with N wait cycles.
- ReadDataW loads the extended dmem_rdata only on load completion; otherwise it holds its value. ALUOutW loads ALUOutM.
- dmem_ready outside a request is ignored.
- Reset mid-WAIT aborts the access: IDLE, outputs cleared; the bus sees dmem_req drop.

Test Plan:
- Load word, addr 0x100, dmem_rdata 0xDEADBEEF, ready same cycle -> next cycle ReadDataW=0xDEADBEEF, MemToRegW=1, StallM never high.
- Signed byte load, addr 0x103, rdata 0x80112233 -> be=1000, ReadDataW=0xFFFFFF80; the same load unsigned gives 0x00000080.
- Store half, addr 0x102, WriteDataM 0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1; RegWriteW=0.
- Load with ready after 3 cycles -> StallM high 3 cycles, W outputs are bubbles meanwhile, then data appears one cycle after ready; a following ALU instruction arrives next.
- Word load at 0x101 -> no dmem_req, ExcM=01 one cycle, RegWriteW=0.
- TIMEOUT=4, ready never asserted -> StallM high 4 cycles, then ExcM=10 pulse, back to IDLE. Then assert rst_n=0 mid-WAIT on a retry -> all outputs 0 immediately.
